// File: rtl/ahb_master_arbiter.sv
// AHB master arbiter: parks on the last owner, hands the bus round-robin on release
// or quantum expiry, and never moves the grant while the bus is stalled or locked.
module ahb_master_arbiter #(
    parameter logic [3:0] M_ENABLE       = 4'b1111,
    parameter logic [1:0] DEFAULT_MASTER = 2'd0,
    parameter int         QUANTUM        = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] HREQ,
    input  logic [3:0] HLOCK,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic [1:0] HMSEL,
    output logic [3:0] HGRANT,
    output logic       HMASTLOCK,
    output logic       dbg_state,
    output logic [7:0] dbg_qcount
);

    // Handshake: a decision is taken only in a cycle where HREADY=1; the new owner
    // appears on HMSEL/HGRANT after the next rising edge of HCLK.

    typedef enum logic {
        PARK  = 1'b0,
        OWNED = 1'b1
    } state_t;

    localparam logic [7:0] QUANTUM_Q = 8'(QUANTUM);

    state_t     state_q, state_d;
    logic [1:0] msel_q, msel_d;
    logic [7:0] qcnt_q, qcnt_d;
    logic       mlock_q, mlock_d;

    logic [3:0] req_en;
    logic [3:0] lock_en;
    logic [3:0] owner_bit;
    logic [3:0] others;
    logic       quantum_hit;
    logic       xfer;

    // First set bit of mask searched from base+1 upward (mod 4); base itself is last.
    function automatic logic [1:0] rr_pick(input logic [3:0] mask, input logic [1:0] base);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            idx = base + 2'(i);
            if (!found && mask[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        req_en      = HREQ & M_ENABLE;
        lock_en     = HLOCK & M_ENABLE;
        owner_bit   = 4'b0001 << msel_q;
        others      = req_en & ~owner_bit;
        quantum_hit = (qcnt_q == QUANTUM_Q);
        xfer        = HREADY && (HTRANS == 2'b10 || HTRANS == 2'b11);

        state_d = state_q;
        msel_d  = msel_q;

        if (HREADY) begin
            case (state_q)
                PARK: begin
                    if (req_en != 4'b0000) begin
                        state_d = OWNED;
                        msel_d  = rr_pick(req_en, msel_q);
                    end
                end
                OWNED: begin
                    if (!lock_en[msel_q]) begin
                        if (others == 4'b0000 && !req_en[msel_q]) begin
                            state_d = PARK;
                        end else if (others != 4'b0000 && (!req_en[msel_q] || quantum_hit)) begin
                            msel_d = rr_pick(others, msel_q);
                        end
                    end
                end
                default: state_d = PARK;
            endcase
        end

        // Counter saturates at QUANTUM so a long locked tenure cannot wrap it.
        if (msel_d != msel_q) begin
            qcnt_d = 8'd0;
        end else if (xfer && !quantum_hit) begin
            qcnt_d = qcnt_q + 8'd1;
        end else begin
            qcnt_d = qcnt_q;
        end

        mlock_d = lock_en[msel_d];
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q <= PARK;
            msel_q  <= DEFAULT_MASTER;
            qcnt_q  <= 8'd0;
            mlock_q <= 1'b0;
        end else begin
            state_q <= state_d;
            msel_q  <= msel_d;
            qcnt_q  <= qcnt_d;
            mlock_q <= mlock_d;
        end
    end

    assign HMSEL      = msel_q;
    assign HGRANT     = 4'b0001 << msel_q;
    assign HMASTLOCK  = mlock_q;
    assign dbg_state  = state_q;
    assign dbg_qcount = qcnt_q;

endmodule

// File: doc/ahb_master_arbiter.md
AHB_MASTER_ARBITER -- requirements
Module: ahb_master_arbiter

Interface
REQ-001 Parameter M_ENABLE, default 4'b1111, per-master enable mask; disabled masters are never granted.
REQ-002 Parameter DEFAULT_MASTER, default 2'd0, owner after reset; must be an enabled master.
REQ-003 Parameter QUANTUM, default 16, range 1..255, maximum accepted transfers per tenure while others request.
REQ-004 HCLK  input  1  bus clock; all state updates on the rising edge.
REQ-005 HRESET  input  1  synchronous, active-high reset.
REQ-006 HREQ  input  4  per-master bus request, bit n = master n.
REQ-007 HLOCK  input  4  per-master lock request; the owner holds it high across any burst or locked sequence.
REQ-008 HTRANS  input  2  address-phase HTRANS of the muxed master output.
REQ-009 HREADY  input  1  HREADY of the muxed master output.
REQ-010 HMSEL  output  2  registered owner index, driven to the downstream master mux select.
REQ-011 HGRANT  output  4  one-hot decode of HMSEL.
REQ-012 HMASTLOCK  output  1  registered; high while the owner's HLOCK bit is high.

Function
REQ-013 Two states, PARK and OWNED, in a registered state variable.
REQ-014 PARK: no enabled master requests; HMSEL holds its last value.
REQ-015 PARK -> OWNED: on any cycle with an enabled HREQ bit high and HREADY=1; the new owner is the first enabled requester searched round-robin from HMSEL+1 (mod 4), the current owner included last.
REQ-016 OWNED -> PARK: HREADY=1, owner HREQ=0, owner HLOCK=0, and no other enabled request.
REQ-017 OWNED handover: HREADY=1, owner HLOCK=0, another enabled master requesting, and either owner HREQ=0 or the quantum counter equals QUANTUM.
REQ-018 The handover target is chosen by round-robin from HMSEL+1, excluding the current owner.
REQ-019 HMSEL and HGRANT update on the clock edge following the decision cycle, giving one-cycle latency.
REQ-020 No change to HMSEL while HREADY=0, regardless of HREQ or HLOCK.
REQ-021 Owner HLOCK=1 blocks every handover, including quantum expiry; the quantum counter saturates at QUANTUM.
REQ-022 Quantum counter is 8 bits, increments on HREADY=1 with HTRANS NONSEQ (2'b10) or SEQ (2'b11), and clears to 0 on every change of owner.
REQ-023 HREQ and HLOCK bits of disabled masters are ignored.
REQ-024 An owner HREQ rising in the same cycle as a handover decision has no effect on that decision.
REQ-025 HGRANT is exactly one-hot at all times.

Reset
REQ-026 HRESET=1 at a clock edge forces state=PARK, HMSEL=DEFAULT_MASTER, HGRANT=one-hot(DEFAULT_MASTER), HMASTLOCK=0, and quantum counter=0.
REQ-027 Reset mid-tenure or mid-lock takes effect immediately with no handshake, and overrides any concurrent decision.
REQ-028 The first arbitration after reset is permitted on the first cycle with HRESET=0.

Verification
REQ-029 Reset, then HREQ=4'b0100 with HREADY=1 -> HMSEL=2 one cycle later, HGRANT=4'b0100.
REQ-030 Owner 0 with HREQ=4'b1111 throughout and NONSEQ transfers with HREADY=1 -> handover to 1 after 16 accepted transfers, then 2, then 3, then 0.
REQ-031 Owner 1 with HLOCK[1]=1 for 40 transfers and HREQ=4'b1111 -> HMSEL stays 1 and HMASTLOCK=1 throughout; handover to 2 on the first HREADY cycle after HLOCK[1] falls.
REQ-032 Handover condition met while HREADY=0 for 5 cycles -> HMSEL unchanged until one cycle after HREADY rises.
REQ-033 M_ENABLE=4'b1011 with HREQ=4'b0100 -> no grant to master 2; state remains PARK.
REQ-034 HRESET asserted mid-tenure with owner 3 and quantum count 7 -> next cycle HMSEL=0, counter=0, HMASTLOCK=0.
